// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - RV32I decode/operand-fetch stage with busy scoreboard and writeback bypass
//
// Purpose:
//   Sits directly in front of the RV32I register file. Decodes the incoming
//   instruction, drives the register-file read addresses, and captures the
//   operands into a one-entry output register. A per-register busy bit
//   marks destinations whose writeback is still outstanding. The stage
//   stalls on RAW and WAW hazards against those bits. Writeback data
//   arriving in the same cycle is forwarded into the operands, so a
//   captured operand is never the stale register-file value.
//
// Optional feature (macro ISSUE_STALL_CNT_EN):
//   When the macro is defined, a 32-bit stall_cnt output is added. It counts
//   the cycles in which an offered instruction is blocked by a hazard.
//   Backpressure-only stalls are not counted. The counter wraps at 2^32.
//   When the macro is undefined, the port and the counter are absent.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   in_valid/in_ready        instruction handshake from fetch
//   in_instr, in_pc          instruction word and its PC
//   rf_rs1, rf_rs2           register-file read addresses (instr[19:15], instr[24:20])
//   rf_rdata1, rf_rdata2     register-file combinational read data
//   wb_valid, wb_rd, wb_data writeback strobe/index/data (also the regfile write)
//   out_valid/out_ready      issued-instruction handshake to execute
//   out_instr, out_pc        registered instruction and PC
//   out_op1, out_op2         registered rs1/rs2 operand values
//   out_rd, out_rd_wen       destination index and its write enable
//   stall_cnt                hazard stall counter (ISSUE_STALL_CNT_EN only)

module operand_issue #(
  parameter int DataWidth    = 32,
  parameter int Registers    = 32,
  parameter int AddrRegWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DataWidth-1:0]    in_instr,
  input  logic [DataWidth-1:0]    in_pc,
  output logic [AddrRegWidth-1:0] rf_rs1,
  output logic [AddrRegWidth-1:0] rf_rs2,
  input  logic [DataWidth-1:0]    rf_rdata1,
  input  logic [DataWidth-1:0]    rf_rdata2,
  input  logic                    wb_valid,
  input  logic [AddrRegWidth-1:0] wb_rd,
  input  logic [DataWidth-1:0]    wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DataWidth-1:0]    out_instr,
  output logic [DataWidth-1:0]    out_pc,
  output logic [DataWidth-1:0]    out_op1,
  output logic [DataWidth-1:0]    out_op2,
  output logic [AddrRegWidth-1:0] out_rd,
  output logic                    out_rd_wen
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  // RV32I major opcodes
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [6:0]              w_opcode;
  logic [AddrRegWidth-1:0] w_rd;
  logic [AddrRegWidth-1:0] w_rs1;
  logic [AddrRegWidth-1:0] w_rs2;
  logic                    w_wr_op;
  logic                    w_uses_rs1;
  logic                    w_uses_rs2;
  logic                    w_rd_wen;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[7 +: AddrRegWidth];
  assign w_rs1    = in_instr[15 +: AddrRegWidth];
  assign w_rs2    = in_instr[20 +: AddrRegWidth];

  // The read addresses come straight from the instruction fields. The
  // register file then returns data in the same cycle.
  assign rf_rs1 = w_rs1;
  assign rf_rs2 = w_rs2;

  always_comb begin
    w_wr_op    = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OpLui, OpAuipc, OpJal: begin
        w_wr_op = 1'b1;
      end
      OpJalr, OpLoad, OpImm: begin
        w_wr_op    = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OpReg: begin
        w_wr_op    = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OpBranch, OpStore: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: begin
        // Unknown opcodes have no sources and no destination. They pass
        // through without touching the scoreboard.
      end
    endcase
  end

  // x0 is never a real destination, so it is never tracked.
  assign w_rd_wen = w_wr_op && (w_rd != '0);

  // ---------------------------------------------------------------------
  // Scoreboard and hazards
  // ---------------------------------------------------------------------
  logic [Registers-1:0]    r_busy;
  logic [Registers-1:0]    w_busy_nxt;
  logic                    w_clr;
  logic                    w_src1_haz;
  logic                    w_src2_haz;
  logic                    w_waw_haz;
  logic                    w_hazard;
  logic                    w_accept;

  logic                    r_out_valid;
  logic [DataWidth-1:0]    r_out_instr;
  logic [DataWidth-1:0]    r_out_pc;
  logic [DataWidth-1:0]    r_out_op1;
  logic [DataWidth-1:0]    r_out_op2;
  logic [AddrRegWidth-1:0] r_out_rd;
  logic                    r_out_rd_wen;

  // A writeback to x0 carries nothing useful. It neither clears a busy bit
  // nor forwards data.
  assign w_clr = wb_valid && (wb_rd != '0);

  // A busy register that is being written back in this cycle is not a
  // hazard. Its value is forwarded from wb_data below.
  assign w_src1_haz = w_uses_rs1 && (w_rs1 != '0) && r_busy[w_rs1]
                      && !(w_clr && (wb_rd == w_rs1));
  assign w_src2_haz = w_uses_rs2 && (w_rs2 != '0) && r_busy[w_rs2]
                      && !(w_clr && (wb_rd == w_rs2));
  assign w_waw_haz  = w_rd_wen && r_busy[w_rd]
                      && !(w_clr && (wb_rd == w_rd));
  assign w_hazard   = w_src1_haz || w_src2_haz || w_waw_haz;

  // in_ready depends on in_valid. It drops only while an offered
  // instruction is actually blocked by a hazard.
  assign in_ready = rst && (!r_out_valid || out_ready) && !(in_valid && w_hazard);
  assign w_accept = in_valid && in_ready;

  // Apply the clear first, then the set. When both hit the same index in
  // one cycle, the newly issued writer keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) begin
      w_busy_nxt[wb_rd] = 1'b0;
    end
    if (w_accept && w_rd_wen) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Operand select with same-cycle writeback bypass
  // ---------------------------------------------------------------------
  logic [DataWidth-1:0] w_op1;
  logic [DataWidth-1:0] w_op2;

  // The register file writes at the end of this cycle, so its read port
  // still shows the old value. Forward wb_data instead when the indices match.
  always_comb begin
    if (w_rs1 == '0) begin
      w_op1 = '0;
    end else if (w_clr && (wb_rd == w_rs1)) begin
      w_op1 = wb_data;
    end else begin
      w_op1 = rf_rdata1;
    end
  end

  always_comb begin
    if (w_rs2 == '0) begin
      w_op2 = '0;
    end else if (w_clr && (wb_rd == w_rs2)) begin
      w_op2 = wb_data;
    end else begin
      w_op2 = rf_rdata2;
    end
  end

  // ---------------------------------------------------------------------
  // Output register and scoreboard state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_pc     <= '0;
      r_out_op1    <= '0;
      r_out_op2    <= '0;
      r_out_rd     <= '0;
      r_out_rd_wen <= 1'b0;
      r_busy       <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        // An accept in the same cycle as a downstream transfer replaces the
        // departing entry. This keeps a throughput of one instruction per
        // cycle.
        r_out_valid  <= 1'b1;
        r_out_instr  <= in_instr;
        r_out_pc     <= in_pc;
        r_out_op1    <= w_op1;
        r_out_op2    <= w_op2;
        r_out_rd     <= w_rd;
        r_out_rd_wen <= w_rd_wen;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign out_pc     = r_out_pc;
  assign out_op1    = r_out_op1;
  assign out_op2    = r_out_op2;
  assign out_rd     = r_out_rd;
  assign out_rd_wen = r_out_rd_wen;

`ifdef ISSUE_STALL_CNT_EN
  // ---------------------------------------------------------------------
  // Hazard stall counter
  // ---------------------------------------------------------------------
  logic [31:0] r_stall_cnt;

  // Only hazard stalls are counted. A cycle blocked only by a full output
  // register is not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_issue.sv
// tb/tb_operand_issue.sv - scoreboard bench for operand_issue against a program-order register model
module tb_operand_issue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  operand_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rf_rs1     (rf_rs1),
    .rf_rs2     (rf_rs2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_rd     (out_rd),
    .out_rd_wen (out_rd_wen)
`ifdef ISSUE_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [4:0]  rd;
    bit          wen;
    bit          u1;
    bit          u2;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] rf [32];       // contents of the physical register file
  logic [31:0] arch [32];     // value each register holds once all accepted instructions retire
  bit          pending [32];  // writeback still owed to execute
  bit          m_occ = 1'b0;  // model: output register holds an instruction
  int          m_stall = 0;
  int          rdy_pct = 100;
  int          wb_pct = 50;
  exp_t        exp_q [$];
  wb_t         wb_q [$];

  assign rf_rdata1 = rf[rf_rs1];
  assign rf_rdata2 = rf[rf_rs2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {rd_wen, uses_rs1, uses_rs2}
  function automatic logic [2:0] dec(input logic [31:0] ins);
    logic [2:0] d;
    d = 3'b000;
    case (ins[6:0])
      7'h37, 7'h17, 7'h6F: d = 3'b100;
      7'h67, 7'h03, 7'h13: d = 3'b110;
      7'h33:               d = 3'b111;
      7'h63, 7'h23:        d = 3'b011;
      default:             d = 3'b000;
    endcase
    if (ins[11:7] == 5'd0) d[2] = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] x;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h63, 7'h23, 7'h73};
    x = $urandom;
    x[6:0]   = ops[$urandom_range(0, 9)];
    x[11:7]  = 5'($urandom_range(0, 3));
    x[19:15] = 5'($urandom_range(0, 3));
    x[24:20] = 5'($urandom_range(0, 3));
    return x;
  endfunction

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic tick(input bit r, input bit v, input logic [31:0] ins,
                      input logic [31:0] pc_i, output bit acc);
    wb_t        w;
    exp_t       e;
    logic [2:0] d;
    logic [4:0] rs1, rs2, rd;
    bit         haz, exp_rdy;
    @(posedge clk);
    #1;
    if (rst && wb_valid && wb_rd != 5'd0) rf[wb_rd] = wb_data;
    rst = r;
    wb_valid = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    if (r && wb_q.size() != 0 && $urandom_range(0, 99) < wb_pct) begin
      w = wb_q.pop_front();
      wb_valid = 1'b1;
      wb_rd = w.rd;
      wb_data = w.val;
      pending[w.rd] = 1'b0;
    end else if (r && $urandom_range(0, 7) == 0) begin
      wb_valid = 1'b1;
      wb_rd = 5'd0;
      wb_data = 32'hFFFF_FFFF;
    end
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    in_valid = v;
    in_instr = ins;
    in_pc = pc_i;
    @(negedge clk);
    d = dec(ins);
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    rd = ins[11:7];
    haz = (d[1] && rs1 != 0 && pending[rs1]) || (d[0] && rs2 != 0 && pending[rs2])
          || (d[2] && pending[rd]);
    exp_rdy = r && (!m_occ || out_ready) && !(v && haz);
    chk("out_valid", 32'(out_valid), 32'(m_occ));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && in_ready;
    if (!r) begin
      acc = 1'b0;
      exp_q.delete();
      wb_q.delete();
      m_occ = 1'b0;
      m_stall = 0;
      for (int i = 0; i < 32; i++) begin
        pending[i] = 1'b0;
        arch[i] = rf[i];
      end
    end else begin
      if (v && haz) m_stall++;
      if (acc) begin
        e.instr = ins;
        e.pc = pc_i;
        e.rd = rd;
        e.wen = d[2];
        e.u1 = d[1];
        e.u2 = d[0];
        e.op1 = (rs1 == 0) ? 32'd0 : arch[rs1];
        e.op2 = (rs2 == 0) ? 32'd0 : arch[rs2];
        e.res = $urandom;
        if (d[2]) begin
          arch[rd] = e.res;
          pending[rd] = 1'b1;
        end
        exp_q.push_back(e);
        m_occ = 1'b1;
      end else if (out_ready) begin
        m_occ = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc_i, output int cyc);
    bit acc;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 200) begin
      tick(1'b1, 1'b1, ins, pc_i, acc);
      cyc++;
    end
    if (!acc) chk("issue_timeout", 32'(acc), 32'd1);
  endtask

  task automatic reset_dut();
    bit acc;
    tick(1'b0, 1'b0, 32'd0, 32'd0, acc);
    tick(1'b1, 1'b0, 32'd0, 32'd0, acc);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_op1", out_op1, 32'd0);
    chk("rst_out_op2", out_op2, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
  endtask

  // Monitor: compares whatever the output register presents with the oldest
  // expected entry, and releases the entry only on a downstream transfer.
  task automatic monitor();
    exp_t e;
    wb_t  w;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("out_instr", out_instr, e.instr);
          chk("out_pc", out_pc, e.pc);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_rd_wen", 32'(out_rd_wen), 32'(e.wen));
          if (e.u1) chk("out_op1", out_op1, e.op1);
          if (e.u2) chk("out_op2", out_op2, e.op2);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (e.wen) begin
              w.rd = e.rd;
              w.val = e.res;
              wb_q.push_back(w);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int          cyc;
    bit          acc, have, v;
    logic [31:0] ins, pc;
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 0) ? 32'd0 : $urandom;
      pending[i] = 1'b0;
    end
    rf[1] = 32'd7;
    rf[2] = 32'd9;
    fork
      monitor();
    join_none

    reset_dut();

    // Directed sequence: independent add, RAW through x1, store, WAW, nop.
    rdy_pct = 100;
    wb_pct = 50;
    issue(32'h002081B3, 32'h100, cyc);
    issue(32'h00500093, 32'h104, cyc);
    issue(32'h002081B3, 32'h108, cyc);
    issue(32'h00112023, 32'h10C, cyc);
    issue(32'h00500093, 32'h110, cyc);
    issue(32'h00500093, 32'h114, cyc);
    issue(32'h00000013, 32'h118, cyc);

    // Backpressure: the output is held for three cycles, then drains back-to-back.
    issue(32'h00000013, 32'h11C, cyc);
    rdy_pct = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 32'h00000013, 32'h120, acc);
    rdy_pct = 100;
    issue(32'h00000013, 32'h120, cyc);
    chk("backpressure_b2b_cycles", 32'(cyc), 32'd1);

    // Reset while an instruction is in flight and x1 is busy.
    issue(32'h00500093, 32'h200, cyc);
    rdy_pct = 0;
    tick(1'b1, 1'b0, 32'd0, 32'd0, acc);
    reset_dut();
    rdy_pct = 100;
    issue(32'h00308193, 32'h204, cyc);
    chk("post_reset_no_stall", 32'(cyc), 32'd1);

    // Randomized traffic over a small register set to force frequent hazards.
    rdy_pct = 75;
    wb_pct = 40;
    have = 1'b0;
    ins = '0;
    pc = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!have) begin
        ins = rand_instr();
        pc = $urandom;
        have = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      tick(($urandom_range(0, 599) != 0), v, ins, pc, acc);
      if (acc) have = 1'b0;
    end

    rdy_pct = 100;
    wb_pct = 100;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 32'd0, 32'd0, acc);
    chk("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef ISSUE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Decode/operand-fetch stage sitting directly upstream of the RV32I register file.
- Drives the register-file read addresses and captures the read data into a one-entry output register.
- Tracks pending destination writes in a scoreboard and stalls on RAW/WAW hazards.
- Bypasses same-cycle writeback data so operands are never stale.

Parameters:
DataWidth, 32, width of instruction, PC and operand data
Registers, 32, number of architectural registers (scoreboard depth)
AddrRegWidth, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset
in_valid  in  1  fetched instruction available
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  DataWidth  instruction word
in_pc  in  DataWidth  instruction PC
rf_rs1  out  AddrRegWidth  regfile read address 1 = in_instr[19:15]
rf_rs2  out  AddrRegWidth  regfile read address 2 = in_instr[24:20]
rf_rdata1  in  DataWidth  regfile combinational read data 1
rf_rdata2  in  DataWidth  regfile combinational read data 2
wb_valid  in  1  writeback this cycle (same strobe drives regfile wen)
wb_rd  in  AddrRegWidth  writeback destination
wb_data  in  DataWidth  writeback data
out_valid  out  1  issued instruction held
out_ready  in  1  downstream accepts
out_instr, out_pc  out  DataWidth  registered instruction / PC
out_op1, out_op2  out  DataWidth  registered rs1/rs2 operand values
out_rd  out  AddrRegWidth  destination index
out_rd_wen  out  1  instruction writes rd

Behaviour:
- Reset (rst==0 at an edge): out_valid=0; out_instr, out_pc, out_op1, out_op2, out_rd, out_rd_wen all 0; all busy bits 0. In-flight entry is discarded. wb_valid is ignored during reset.
- Decode from opcode in_instr[6:0]:
  - rd_wen: opcode in {0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011} and rd!=0.
  - uses_rs1: {1100111, 1100011, 0000011, 0100011, 0010011, 0110011}.
  - uses_rs2: {1100011, 0100011, 0110011}.
  - Unknown opcodes: rd_wen=0, no sources.
- Writeback clear: clr = wb_valid && wb_rd!=0.
- Hazards:
  - Source hazard: source used, index!=0, busy[idx]=1, and not (clr && wb_rd==idx).
  - WAW hazard: rd_wen and busy[rd] and not (clr && wb_rd==rd).
- Ready: in_ready = rst && (!out_valid || out_ready) && !(in_valid && (source hazard || WAW hazard)).
- Accept = in_valid && in_ready. Next edge:
  - Output register loads instr, pc, rd, rd_wen; out_valid=1.
  - Operand = wb_data if clr && wb_rd==idx && idx!=0; else 0 if idx==0; else rf_rdata.
- Downstream transfer: out_valid && out_ready with no accept clears out_valid. Accept and transfer in the same cycle makes the new instruction replace the old one. Fully pipelined throughput: 1 instruction/cycle.
- Output register is stable while out_valid && !out_ready.
- Scoreboard:
  - On accept with rd_wen, busy[rd] set.
  - On clr, busy[wb_rd] cleared.
  - Set and clear of the same index in the same cycle: set wins.
  - Clear of a non-busy register is a no-op. busy[0] is never set.
- Latency: in_instr to out_valid is 1 cycle when hazard-free.

Optional Feature:
- Macro ISSUE_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], reset to 0. It increments by 1 on every cycle with rst=1, in_valid=1 and a source or WAW hazard. It wraps from 0xFFFFFFFF to 0. Backpressure-only stalls are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset mid-stream: out_valid=1, busy[1]=1, then rst=0 for 1 cycle -> out_valid=0, all outputs 0, busy cleared; next addi x3,x1,... issues without stall.
- Hazard-free issue: regfile x1=7, x2=9, in_instr=0x002081B3 (add x3,x1,x2), pc=0x100 -> next cycle out_valid=1, out_op1=7, out_op2=9, out_rd=3, out_rd_wen=1.
- RAW stall and bypass: issue 0x00500093 (addi x1,x0,5), then 0x002081B3 -> in_ready=0 until wb_valid, wb_rd=1, wb_data=5 asserted. In that cycle in_ready=1 and out_op1=5 (bypassed, not the stale regfile value).
- Store/WAW: with busy[1] set, 0x00112023 (sw x1,0(x2)) stalls on rs2. Issuing addi x1 while busy[1] stalls (WAW) until wb_rd=1.
- Backpressure: out_ready=0 for 3 cycles -> out_* held constant, in_ready=0. Then out_ready=1 with in_valid -> back-to-back transfer, no bubble.
- x0 handling: 0x00000013 (nop) sets no busy bit; wb_valid with wb_rd=0, wb_data=0xFFFFFFFF changes nothing. With ISSUE_STALL_CNT_EN, 4 hazard cycles give stall_cnt=4.
